// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: shared state encoding, default widths and burst-end helper for ram_burst_ctrl.
package ram_burst_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_LEN_WIDTH  = 4;

    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPTURE, RD_RESP} state_t;

    typedef struct packed {
        logic        ovf;
        logic [31:0] end_addr;
    } burst_end_t;

    // Last address touched by a burst, flagged when it runs past the top of an aw-bit space.
    function automatic burst_end_t burst_end(input logic [31:0] addr, input logic [31:0] len,
                                             input int unsigned aw);
        logic [32:0] sum;
        burst_end_t  r;
        sum        = {1'b0, addr} + {1'b0, len};
        r.ovf      = (sum >> aw) != '0;
        r.end_addr = sum[31:0];
        return r;
    endfunction

endpackage

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst read/write sequencer in front of a single-port registered-read RAM.
// Define RAM_BURST_CTRL_BOUND_CHK_EN to reject bursts that would run past the top address (err port).
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
    ,
    output logic                  err
`endif
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Handshakes are gated by rst_n so a burst cut by reset cannot write on the reset edge.
    assign cmd_ready = rst_n && state_q == IDLE;
    assign wd_ready  = rst_n && state_q == WR;
    assign ram_we    = wd_ready && wd_valid;
    assign ram_addr  = state_q == IDLE ? '0 : addr_q;
    assign ram_wdata = state_q == WR ? wd_data : '0;
    assign rsp_valid = state_q == RD_RESP;
    assign rsp_data  = rsp_q;
    assign done      = done_q;
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
    assign err       = err_q;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rsp_d   = rsp_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                rem_d   = cmd_len;
                state_d = cmd_write ? WR : RD_ISSUE;
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
                if (burst_end(32'(cmd_addr), 32'(cmd_len), ADDR_WIDTH).ovf) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
`endif
            end
            WR: if (wd_valid) begin
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                if (rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            RD_ISSUE: state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                rsp_d   = ram_rdata;
                state_d = RD_RESP;
            end
            RD_RESP: if (rsp_ready) begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rsp_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rsp_q   <= rsp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed scenarios against ram_burst_ctrl driving a behavioural registered-read RAM.
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic       wd_valid = 1'b0, wd_ready;
    logic [7:0] wd_data = '0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       done, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] wlog_a [512];
    logic [7:0] wlog_d [512];
    int         wcount = 0;
    int         dcount = 0;
    logic [7:0] rd [16];

    ram_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .done(done), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wlog_a[wcount % 512] <= ram_addr;
            wlog_d[wcount % 512] <= ram_wdata;
            wcount <= wcount + 1;
        end
        ram_rdata <= mem[ram_addr];
        if (done) dcount <= dcount + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] l, input logic [7:0] base, input bit gap);
        issue(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            wd_valid = 1'b1; wd_data = 8'(base + i);
            tick();
            wd_valid = 1'b0;
            if (gap && i != int'(l)) tick();
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] l);
        issue(1'b0, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            int t = 0;
            while (!rsp_valid && t < 10) begin tick(); t++; end
            rd[i] = rsp_valid ? rsp_data : 8'hxx;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (ram_we !== 1'b0 || wd_ready !== 1'b0 || rsp_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got we%b wr%b rv%b d%b exp 0000", ram_we, wd_ready, rsp_valid, done); end
        checks++; if (ram_addr !== 8'h00 || rsp_data !== 8'h00 || ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_data got a%h r%h w%h exp 00", ram_addr, rsp_data, ram_wdata); end
    endtask

    task automatic test_single();
        int w0 = wcount;
        issue(1'b1, 8'h04, 4'd0);
        wd_valid = 1'b1; wd_data = 8'h12;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h04 || ram_wdata !== 8'h12) begin errors++; $display("FAIL single_wr_port got we%b a%h d%h exp 1 04 12", ram_we, ram_addr, ram_wdata); end
        tick();
        wd_valid = 1'b0;
        checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL single_wr_done got d%b rdy%b exp 1 1", done, cmd_ready); end
        checks++; if (wcount - w0 !== 1 || wlog_a[w0 % 512] !== 8'h04) begin errors++; $display("FAIL single_wr_count got %0d @%h exp 1 @04", wcount - w0, wlog_a[w0 % 512]); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", done); end
        issue(1'b0, 8'h04, 4'd0);
        checks++; if (rsp_valid !== 1'b0 || ram_addr !== 8'h04 || ram_we !== 1'b0) begin errors++; $display("FAIL single_rd_c1 got rv%b a%h we%b exp 0 04 0", rsp_valid, ram_addr, ram_we); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rd_c2 got %b exp 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h12) begin errors++; $display("FAIL single_rd_c3 got rv%b %h exp 1 12", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (done !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rd_done got d%b rv%b exp 1 0", done, rsp_valid); end
    endtask

    task automatic test_burst();
        int w0 = wcount;
        do_write(8'h10, 4'd3, 8'h34, 1'b1);
        checks++; if (done !== 1'b1 || wcount - w0 !== 4) begin errors++; $display("FAIL burst_wr got d%b n%0d exp 1 4", done, wcount - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wlog_a[(w0 + i) % 512] !== 8'(8'h10 + i) || wlog_d[(w0 + i) % 512] !== 8'(8'h34 + i)) begin errors++; $display("FAIL burst_wr_beat%0d got %h:%h exp %h:%h", i, wlog_a[(w0 + i) % 512], wlog_d[(w0 + i) % 512], 8'(8'h10 + i), 8'(8'h34 + i)); end
        end
        tick();
        do_read(8'h10, 4'd3);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd[i] !== 8'(8'h34 + i)) begin errors++; $display("FAIL burst_rd_beat%0d got %h exp %h", i, rd[i], 8'(8'h34 + i)); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL burst_rd_done got %b exp 1", done); end
        tick();
    endtask

    task automatic test_wrap();
        int w0 = wcount;
`ifdef RAM_BURST_CTRL_BOUND_CHK_EN
        issue(1'b1, 8'hFE, 4'd2);
        checks++; if (err !== 1'b1 || done !== 1'b1 || cmd_ready !== 1'b1 || wd_ready !== 1'b0) begin errors++; $display("FAIL bound_reject got e%b d%b rdy%b wr%b exp 1 1 1 0", err, done, cmd_ready, wd_ready); end
        tick();
        checks++; if (err !== 1'b0 || done !== 1'b0 || wcount - w0 !== 0) begin errors++; $display("FAIL bound_after got e%b d%b n%0d exp 0 0 0", err, done, wcount - w0); end
`else
        do_write(8'hFE, 4'd2, 8'hA0, 1'b0);
        checks++; if (wcount - w0 !== 3 || wlog_a[w0 % 512] !== 8'hFE || wlog_a[(w0 + 1) % 512] !== 8'hFF || wlog_a[(w0 + 2) % 512] !== 8'h00) begin errors++; $display("FAIL wrap_wr_addr got n%0d %h %h %h exp 3 FE FF 00", wcount - w0, wlog_a[w0 % 512], wlog_a[(w0 + 1) % 512], wlog_a[(w0 + 2) % 512]); end
        tick();
        do_read(8'hFE, 4'd2);
        checks++; if (rd[0] !== 8'hA0 || rd[1] !== 8'hA1 || rd[2] !== 8'hA2) begin errors++; $display("FAIL wrap_rd got %h %h %h exp A0 A1 A2", rd[0], rd[1], rd[2]); end
        tick();
`endif
    endtask

    task automatic test_backpressure();
        issue(1'b0, 8'h10, 4'd1);
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h34) begin errors++; $display("FAIL bp_first got rv%b %h exp 1 34", rsp_valid, rsp_data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h34 || ram_addr !== 8'h10) begin errors++; $display("FAIL bp_hold%0d got rv%b %h a%h exp 1 34 10", i, rsp_valid, rsp_data, ram_addr); end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || ram_addr !== 8'h11 || done !== 1'b0) begin errors++; $display("FAIL bp_next_issue got rv%b a%h d%b exp 0 11 0", rsp_valid, ram_addr, done); end
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h35) begin errors++; $display("FAIL bp_second got rv%b %h exp 1 35", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
        tick();
    endtask

    task automatic test_mid_reset();
        int w0, d0;
        do_write(8'h40, 4'd3, 8'hE0, 1'b0);
        tick();
        w0 = wcount;
        d0 = dcount;
        issue(1'b1, 8'h40, 4'd3);
        wd_valid = 1'b1; wd_data = 8'h50;
        tick();
        wd_data = 8'h51;
        rst_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL midrst_we_low got %b exp 0", ram_we); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midrst_after got we%b rdy%b d%b exp 0 1 0", ram_we, cmd_ready, done); end
        wd_valid = 1'b0;
        tick();
        checks++; if (wcount - w0 !== 1 || dcount - d0 !== 0) begin errors++; $display("FAIL midrst_counts got w%0d d%0d exp 1 0", wcount - w0, dcount - d0); end
        do_read(8'h40, 4'd3);
        checks++; if (rd[0] !== 8'h50 || rd[1] !== 8'hE1 || rd[2] !== 8'hE2 || rd[3] !== 8'hE3) begin errors++; $display("FAIL midrst_contents got %h %h %h %h exp 50 E1 E2 E3", rd[0], rd[1], rd[2], rd[3]); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_write(8'h20, 4'd0, 8'h77, 1'b0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_len = 4'd0;
        #1;
        checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept got d%b rdy%b exp 1 1", done, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0 || ram_addr !== 8'h20 || done !== 1'b0) begin errors++; $display("FAIL b2b_issue got rdy%b a%h d%b exp 0 20 0", cmd_ready, ram_addr, done); end
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h77) begin errors++; $display("FAIL b2b_data got rv%b %h exp 1 77", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator-side controller that drives the single-port synchronous RAM (ram_simple: clk, we, addr, data_in, data_out).
- Accepts burst read/write commands on a valid/ready command channel.
- Sequences the individual RAM accesses with incrementing address.
- Takes write beats from a valid/ready write-data stream; returns read beats on a valid/ready response stream.
- Sits between bus-side logic and the RAM instance; it is the only agent driving the RAM port.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width (depth 2^ADDR_WIDTH).
- LEN_WIDTH, 4, burst length field width; burst = cmd_len+1 beats (1..16).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- wd_valid  in  1  write beat present.
- wd_ready  out  1  write beat accepted.
- wd_data  in  DATA_WIDTH  write beat data.
- rsp_valid  out  1  read beat available.
- rsp_ready  in  1  consumer accepts read beat.
- rsp_data  out  DATA_WIDTH  read beat data.
- done  out  1  one-cycle pulse after last beat of any burst.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM data_in.
- ram_rdata  in  DATA_WIDTH  from RAM data_out; valid one cycle after address presented (registered read).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: state IDLE; cur_addr, beat count, rsp_data = 0; all outputs 0 except cmd_ready = 1 once out of reset.
- Mid-burst reset: abandons the burst, no further RAM writes, no done pulse.
- States: IDLE, WR, RD_ISSUE, RD_CAPTURE, RD_RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_addr→cur_addr and cmd_len→remaining.
  - Go to WR if cmd_write, else RD_ISSUE.
  - cmd_ready = 0 in every other state.
- WR:
  - wd_ready = 1.
  - ram_we = wd_valid (combinational); ram_addr = cur_addr; ram_wdata = wd_data. The RAM writes on the same edge as the handshake.
  - Per accepted beat: cur_addr+1, remaining-1.
  - After the beat with remaining == 0: IDLE, done = 1 next cycle.
  - wd_valid low: stall, ram_we = 0.
- RD_ISSUE: ram_addr = cur_addr, ram_we = 0 for one cycle → RD_CAPTURE.
- RD_CAPTURE: register ram_rdata into rsp_data → RD_RESP.
- RD_RESP:
  - rsp_valid = 1; rsp_data held stable until rsp_ready.
  - On handshake: if remaining == 0, go to IDLE with done pulse; else cur_addr+1, remaining-1, → RD_ISSUE.
  - Read throughput: 1 beat per 3 cycles with rsp_ready tied high.
- ram_we is 0 in every state except WR. ram_addr holds cur_addr in all non-IDLE states and 0 in IDLE.
- Address arithmetic: modulo 2^ADDR_WIDTH; 0xFF+1 → 0x00 (default build).
- Back-to-back commands: a new command is accepted in the IDLE cycle immediately following the last beat, so done and cmd_ready are high together.
- wd_valid asserted outside WR is ignored (wd_ready = 0). rsp_ready outside RD_RESP is ignored.

Optional Feature:
Macro RAM_BURST_CTRL_BOUND_CHK_EN.
- Defined:
  - Adds output err (1 bit).
  - A command with cmd_addr + cmd_len > 2^ADDR_WIDTH-1 is accepted: cmd_ready handshake completes.
  - No RAM access, no wd/rsp beats; err = 1 and done = 1 for one cycle; return to IDLE.
- Undefined: no err port; bursts wrap modulo depth as above.

Decomposition:
- Package ram_burst_pkg:
  - state enum (IDLE, WR, RD_ISSUE, RD_CAPTURE, RD_RESP);
  - default width localparams;
  - a function computing burst end address with overflow flag, used by the bound check.
- No sub-module needed. An optional leaf ram_burst_addr_gen (cur_addr/remaining counters with load/step/last) is acceptable but not required.

Test Plan:
- Single write then read: cmd write addr 0x04 len 0, wd_data 0x12 → ram_we high exactly one cycle with ram_addr 0x04, done. Then read addr 0x04 len 0 → rsp_data 0x12, rsp_valid 3 cycles after cmd handshake.
- Burst write/read: write addr 0x10 len 3 data 0x34,0x35,0x36,0x37 with wd_valid gaps → four RAM writes at 0x10–0x13. Read back len 3 → 0x34..0x37 in order.
- Wrap: write addr 0xFE len 2 data 0xA0,0xA1,0xA2 → writes at 0xFE, 0xFF, 0x00. With RAM_BURST_CTRL_BOUND_CHK_EN: no writes, err = 1, done = 1 one cycle.
- Response backpressure: read len 1 with rsp_ready low 5 cycles → rsp_valid held, rsp_data stable, no new ram_addr issued until handshake.
- Mid-burst reset: rst_n low during beat 2 of a 4-beat write → after one clk, ram_we = 0, cmd_ready = 1, no done. The remaining addresses retain their old contents.
- Back-to-back: read command issued in the cycle after done → accepted immediately (cmd_ready = 1 in that cycle).
